mem_arbiter: RTL and testbench

Two-master arbiter sharing one single-port synchronous memory (1-cycle read latency) between the core's bus port (port 0) and a secondary master such as a program loader or debug port (port 1). It sits between the masters and the RAM and issues at most one access per cycle. Each access gets a grant in its issue cycle and a completion strobe one cycle later. An optional lock lets the owning master keep the memory for short read-modify-write sequences.

---
 rtl/mem_arb_pkg.sv | 6 +
 rtl/arb_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 76 +++++++
 tb/tb_mem_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the two-port memory arbiter
package mem_arb_pkg;
  localparam int NPORTS = 2;
  typedef logic [$clog2(NPORTS)-1:0] port_t;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_e;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational one-hot picker; MEM_ARB_RR_EN selects round-robin, otherwise port 0 has fixed priority
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req_i,
  input  port_t             rr_last_i,
  input  logic [NPORTS-1:0] mask_i,
  output logic [NPORTS-1:0] gnt_o
);
  logic [NPORTS-1:0] r;
`ifdef MEM_ARB_RR_EN
  // On contention the port that was not granted last wins
  always_comb begin
    r = req_i & mask_i;
    gnt_o = &r ? (rr_last_i ? 2'b01 : 2'b10) : r;
  end
`else
  logic unused_rr;
  // On contention port 0 always wins
  always_comb begin
    r = req_i & mask_i;
    unused_rr = ^rr_last_i;
    gnt_o = &r ? 2'b01 : r;
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter for a single-port 1-cycle-latency RAM, with bounded lock; MEM_ARB_RR_EN selects round-robin
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NPORTS-1:0]   req_i,
  input  logic [NPORTS-1:0]   lock_i,
  input  logic [DATA_W/8-1:0] wstrb_i [NPORTS],
  input  logic [ADDR_W-1:0]   addr_i  [NPORTS],
  input  logic [DATA_W-1:0]   wdata_i [NPORTS],
  output logic [NPORTS-1:0]   gnt_o,
  output logic [NPORTS-1:0]   done_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                mem_en_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  arb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  port_t rr_last_q, rr_last_d, owner, g;
  logic [NPORTS-1:0] done_q, mask, gnt;
  logic rd_q, locked, sat, hold, any;
  // A saturated lock counter releases the lock for one arbitration; reset blocks every grant
  always_comb begin
    owner = port_t'(state_q == OWN1);
    sat = cnt_q == CW'(MAX_LOCK);
    locked = state_q != IDLE && lock_i[owner];
    hold = locked && !sat;
    mask = rst_i ? 2'b00 : hold ? (owner ? 2'b10 : 2'b01) : 2'b11;
  end
  arb_pick u_pick (
    .req_i    (req_i),
    .rr_last_i(rr_last_q),
    .mask_i   (mask),
    .gnt_o    (gnt)
  );
  // Next owner, lock counter and the memory request taken from the granted port
  always_comb begin
    any = |gnt;
    g = port_t'(gnt[1]);
    state_d = any ? (g ? OWN1 : OWN0) : hold ? state_q : IDLE;
    cnt_d = (locked && state_d == state_q) ? (sat ? cnt_q : cnt_q + CW'(1)) : '0;
    rr_last_d = any ? g : rr_last_q;
    mem_en_o = any;
    mem_wstrb_o = any ? wstrb_i[g] : '0;
    mem_addr_o = any ? addr_i[g] : '0;
    mem_wdata_o = any ? wdata_i[g] : '0;
  end
  assign gnt_o = gnt;
  assign done_o = rst_i ? '0 : done_q;
  assign rdata_o = (|done_o && rd_q) ? mem_rdata_i : '0;
  // Owner state and a completion strobe one cycle behind each grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rr_last_q <= 1'b1;
      done_q <= '0;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rr_last_q <= rr_last_d;
      done_q <= gnt;
      rd_q <= mem_wstrb_o == '0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural RAM; follows MEM_ARB_RR_EN for contention expectations
module tb_mem_arbiter;
  import mem_arb_pkg::*;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct packed {logic [1:0] g; logic [31:0] d;} sb_t;
  logic clk = 1'b0, rst;
  logic [1:0] req, lock, gnt_o, done_o;
  logic [3:0] wstrb [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata;
  logic [3:0] mem_wstrb_o;
  logic mem_en_o;
  logic [31:0] ram [64];
  logic [31:0] exp_rd [2];
  sb_t q[$];
  int errs = 0, checks = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock),
    .wstrb_i(wstrb), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o),
    .mem_en_o(mem_en_o), .mem_wstrb_o(mem_wstrb_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | i);
    end else if (mem_en_o) begin
      for (int b = 0; b < 4; b++) if (mem_wstrb_o[b]) ram[mem_addr_o[7:2]][8*b+:8] <= mem_wdata_o[8*b+:8];
      mem_rdata <= ram[mem_addr_o[7:2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    sb_t e;
    if (done_o != 2'b00) begin
      if (q.size() == 0) check("done_unexpected", done_o, 0);
      else begin
        e = q.pop_front();
        check("done_port", done_o, e.g);
        check("rdata", rdata_o, e.d);
      end
    end else check("rdata_idle", rdata_o, 0);
  end

  task automatic tick(input string tag, input logic [1:0] eg, input bit sb);
    @(negedge clk);
    check(tag, gnt_o, eg);
    if (sb && eg != 2'b00) q.push_back({eg, eg[1] ? exp_rd[1] : exp_rd[0]});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [1:0] eg);
    tick(tag, eg, 1'b1);
    nxt();
  endtask

  task automatic drive(input int p, input logic r, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    req[p] = r;
    wstrb[p] = s;
    addr[p] = a;
    wdata[p] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    lock = 2'b00;
    repeat (2) nxt();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    lock = 2'b00;
    drive(0, 1'b1, 4'h0, 32'h04, 32'h0);
    drive(1, 1'b1, 4'h0, 32'h08, 32'h0);
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    @(negedge clk);
    check("rst_gnt", gnt_o, 0);
    check("rst_done", done_o, 0);
    check("rst_en", mem_en_o, 0);
    check("rst_addr", mem_addr_o, 0);
    nxt();
    req = 2'b00;
    rst = 1'b0;
    cyc("idle", 2'b00);

    drive(0, 1'b1, 4'h0, 32'h10, 32'h0);
    exp_rd[0] = 32'hDEADBEEF;
    tick("t1_gnt", 2'b01, 1'b1);
    check("t1_addr", mem_addr_o, 32'h10);
    check("t1_en", mem_en_o, 1);
    check("t1_wstrb", mem_wstrb_o, 0);
    nxt();
    req[0] = 1'b0;
    cyc("t1_idle", 2'b00);

    do_reset();
    drive(0, 1'b1, 4'h0, 32'h04, 32'h0);
    drive(1, 1'b1, 4'h0, 32'h08, 32'h0);
    exp_rd[0] = 32'hC0DE0001;
    exp_rd[1] = 32'hC0DE0002;
    for (int i = 0; i < 4; i++) cyc("t2_contend", (RR && i % 2 == 1) ? 2'b10 : 2'b01);
    req = 2'b00;
    cyc("t2_end", 2'b00);

    drive(1, 1'b1, 4'h0, 32'h08, 32'h0);
    lock[1] = 1'b1;
    cyc("t3_own", 2'b10);
    req[0] = 1'b1;
    for (int i = 0; i < 4; i++) cyc("t3_locked", 2'b10);
    cyc("t3_forced", 2'b01);
    req[0] = 1'b0;
    cyc("t3_p1", 2'b10);
    req = 2'b01;
    cyc("t3_lock_noreq", 2'b00);
    lock[1] = 1'b0;
    cyc("t3_release", 2'b01);
    req = 2'b00;
    cyc("t3_end", 2'b00);

    drive(1, 1'b1, 4'b0001, 32'h20, 32'hFFFFFFA5);
    exp_rd[1] = 32'h0;
    tick("t4_wr", 2'b10, 1'b1);
    check("t4_wstrb", mem_wstrb_o, 4'b0001);
    check("t4_addr", mem_addr_o, 32'h20);
    check("t4_wdata", mem_wdata_o, 32'hFFFFFFA5);
    nxt();
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(0, 1'b1, 4'h0, 32'h20, 32'h0);
    exp_rd[0] = 32'hC0DE00A5;
    cyc("t4_rd", 2'b01);
    req = 2'b00;
    cyc("t4_end", 2'b00);

    drive(0, 1'b1, 4'h0, 32'h10, 32'h0);
    tick("t5_gnt", 2'b01, 1'b0);
    nxt();
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    check("t5_done", done_o, 0);
    check("t5_rdata", rdata_o, 0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    check("t5_gnt_after", gnt_o, 0);
    check("t5_done_after", done_o, 0);
    check("t5_en_after", mem_en_o, 0);
    check("t5_bus_after", {mem_wstrb_o, mem_addr_o, mem_wdata_o}, 0);
    check("t5_state", dut.state_q, IDLE);
    nxt();

    cyc("final_idle", 2'b00);
    check("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
